// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared widths, requester encoding and decode helper for the register-file
// write-back scheduler.
package regfile_wb_scheduler_pkg;
   localparam int XLEN = 32;
   localparam int AW   = 5;
   localparam int NREG = 2**AW;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_LSU = 1'b1
   } req_e;

   function automatic logic [NREG-1:0] dec_onehot(input logic [AW-1:0] idx);
      dec_onehot = {{(NREG-1){1'b0}}, 1'b1} << idx;
   endfunction
endpackage

// File: rtl/regfile_wb_scheduler_chk.sv
// Scoreboard checker. A busy bit must never be set and retired at the same edge,
// because the WAW stall holds any issue whose destination is still pending.
module regfile_wb_scheduler_chk
   import regfile_wb_scheduler_pkg::*;
(
   input logic          CLK,
   input logic          RST,
   input logic          set_en,
   input logic [AW-1:0] set_idx,
   input logic          clr_busy_en,
   input logic [AW-1:0] clr_idx
);

   a_no_set_clr_collision: assert property (@(posedge CLK) disable iff (!RST)
      !(set_en && clr_busy_en && (set_idx == clr_idx)));

endmodule

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter. Bit 0 is the ALU and bit 1 is the LSU.
// On a tie, the requester that did not win last time is granted.
module regfile_wb_scheduler_rr_arbiter2
   import regfile_wb_scheduler_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   req_e rr_last_r;

   // Grant selection: a single requester always wins; a tie goes to the requester that is not rr_last
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (rr_last_r == REQ_LSU) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   // rr_last only moves when a grant is issued
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rr_last_r <= REQ_LSU;
      end else if (gnt != 2'b00) begin
         rr_last_r <= gnt[1] ? REQ_LSU : REQ_ALU;
      end else begin
         rr_last_r <= rr_last_r;
      end
   end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: arbitrates the ALU and LSU onto the single register-file
// write port, and keeps the pending-write scoreboard that drives decode stalls.
module regfile_wb_scheduler
   import regfile_wb_scheduler_pkg::*;
(
   input  logic            CLK,
   input  logic            RST,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_rs1,
   input  logic [AW-1:0]   iss_rs2,
   input  logic [AW-1:0]   iss_rd,
   input  logic            iss_wr,
   output logic            iss_stall,
   input  logic            alu_valid,
   input  logic [AW-1:0]   alu_rd,
   input  logic [XLEN-1:0] alu_data,
   output logic            alu_ready,
   input  logic            lsu_valid,
   input  logic [AW-1:0]   lsu_rd,
   input  logic [XLEN-1:0] lsu_data,
   output logic            lsu_ready,
   output logic            rf_we,
   output logic [AW-1:0]   rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic [NREG-1:0] busy_vec
);

   logic [1:0]      req_s;
   logic [1:0]      gnt_s;
   logic [AW-1:0]   win_rd_s;
   logic [XLEN-1:0] win_data_s;
   logic            set_en_s;
   logic [NREG-1:0] set_mask_s;
   logic [NREG-1:0] clr_mask_s;
   logic [NREG-1:0] busy_nxt_s;
   logic [NREG-1:0] busy_r;

   // Requests are masked while reset is asserted, so no ready can leak out during reset
   assign req_s = {lsu_valid, alu_valid} & {2{RST}};

   regfile_wb_scheduler_rr_arbiter2 u_arb (
      .CLK (CLK),
      .RST (RST),
      .req (req_s),
      .gnt (gnt_s)
   );

   assign alu_ready = gnt_s[0];
   assign lsu_ready = gnt_s[1];
   assign busy_vec  = busy_r;
   assign iss_stall = iss_valid & (busy_r[iss_rs1] | busy_r[iss_rs2] | (iss_wr & busy_r[iss_rd]));

   // Winner mux and scoreboard next state; on a same-edge set/clear, the set wins
   always_comb begin
      win_rd_s   = alu_rd;
      win_data_s = alu_data;
      if (gnt_s[1]) begin
         win_rd_s   = lsu_rd;
         win_data_s = lsu_data;
      end else begin
         win_rd_s   = alu_rd;
         win_data_s = alu_data;
      end
      set_en_s   = iss_valid & iss_wr & ~iss_stall & (iss_rd != {AW{1'b0}});
      set_mask_s = set_en_s ? dec_onehot(iss_rd) : {NREG{1'b0}};
      clr_mask_s = rf_we ? dec_onehot(rf_waddr) : {NREG{1'b0}};
      busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & {{(NREG-1){1'b1}}, 1'b0};
   end

   // Write-port registers; address and data hold unless a real (non-x0) write is launched
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rf_we    <= 1'b0;
         rf_waddr <= {AW{1'b0}};
         rf_wdata <= {XLEN{1'b0}};
         busy_r   <= {NREG{1'b0}};
      end else begin
         busy_r <= busy_nxt_s;
         if ((gnt_s != 2'b00) && (win_rd_s != {AW{1'b0}})) begin
            rf_we    <= 1'b1;
            rf_waddr <= win_rd_s;
            rf_wdata <= win_data_s;
         end else begin
            rf_we    <= 1'b0;
            rf_waddr <= rf_waddr;
            rf_wdata <= rf_wdata;
         end
      end
   end

   regfile_wb_scheduler_chk u_chk (
      .CLK         (CLK),
      .RST         (RST),
      .set_en      (set_en_s),
      .set_idx     (iss_rd),
      .clr_busy_en (rf_we & busy_r[rf_waddr]),
      .clr_idx     (rf_waddr)
   );

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: a vector table, directed corner cases,
// and randomized traffic checked against a behavioural scoreboard/arbiter model.
module tb_regfile_wb_scheduler;
   logic        CLK, RST;
   logic        iss_valid, iss_wr, iss_stall;
   logic [4:0]  iss_rs1, iss_rs2, iss_rd;
   logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
   logic [4:0]  alu_rd, lsu_rd;
   logic [31:0] alu_data, lsu_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] busy_vec;

   regfile_wb_scheduler dut (
      .CLK(CLK), .RST(RST),
      .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
      .iss_wr(iss_wr), .iss_stall(iss_stall),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_vec(busy_vec)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Bench-side register file fed by the write port
   logic [31:0] mem [32];
   always @(posedge CLK) if (rf_we) mem[rf_waddr] <= rf_wdata;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state
   logic [31:0] m_busy;
   logic        m_last_lsu;
   logic        m_we;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   logic        e_ga, e_gl;
   logic        s_stall, s_ar, s_lr;

   task automatic m_reset();
      m_busy = 32'd0; m_last_lsu = 1'b1; m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
   endtask

   // One clock: compare at the falling edge, advance the model, return just after the rising edge
   task automatic tick();
      logic e_stall;
      @(negedge CLK);
      e_stall = iss_valid && (m_busy[iss_rs1] || m_busy[iss_rs2] || (iss_wr && m_busy[iss_rd]));
      if (alu_valid && lsu_valid) begin
         e_ga = m_last_lsu; e_gl = !m_last_lsu;
      end else begin
         e_ga = alu_valid; e_gl = lsu_valid;
      end
      s_stall = iss_stall; s_ar = alu_ready; s_lr = lsu_ready;
      chk("stall", {63'd0, iss_stall}, {63'd0, e_stall});
      chk("alu_ready", {63'd0, alu_ready}, {63'd0, e_ga});
      chk("lsu_ready", {63'd0, lsu_ready}, {63'd0, e_gl});
      chk("rf_we", {63'd0, rf_we}, {63'd0, m_we});
      if (m_we) begin
         chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, m_waddr});
         chk("rf_wdata", {32'd0, rf_wdata}, {32'd0, m_wdata});
      end
      chk("busy_vec", {32'd0, busy_vec}, {32'd0, m_busy});
      if (m_we) m_busy[m_waddr] = 1'b0;
      if (iss_valid && iss_wr && !e_stall && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
      m_busy[0] = 1'b0;
      m_we = 1'b0;
      if (e_ga && alu_rd != 5'd0) begin m_we = 1'b1; m_waddr = alu_rd; m_wdata = alu_data; end
      if (e_gl && lsu_rd != 5'd0) begin m_we = 1'b1; m_waddr = lsu_rd; m_wdata = lsu_data; end
      if (e_ga || e_gl) m_last_lsu = e_gl;
      @(posedge CLK);
      #1;
   endtask

   typedef struct {
      logic av; logic [4:0] ard; logic [31:0] adat;
      logic lv; logic [4:0] lrd; logic [31:0] ldat;
      logic [1:0] eg;
   } vec_t;
   vec_t tbl [12];

   function automatic logic [4:0] pick_rd();
      logic [4:0] r;
      for (int k = 0; k < 8; k++) begin
         r = 5'($urandom_range(1, 7));
         if (m_busy[r]) return r;
      end
      return 5'($urandom_range(0, 31));
   endfunction

   initial begin
      logic exp_we;
      logic [4:0] exp_rd;
      logic [31:0] exp_d;
      tbl[0]  = '{1'b1, 5'd1,  32'h1111_0001, 1'b1, 5'd2,  32'h2222_0002, 2'b01};
      tbl[1]  = '{1'b1, 5'd3,  32'h3333_0003, 1'b1, 5'd2,  32'h2222_0002, 2'b10};
      tbl[2]  = '{1'b1, 5'd3,  32'h3333_0003, 1'b1, 5'd4,  32'h4444_0004, 2'b01};
      tbl[3]  = '{1'b1, 5'd5,  32'h5555_0005, 1'b1, 5'd4,  32'h4444_0004, 2'b10};
      tbl[4]  = '{1'b1, 5'd5,  32'h5555_0005, 1'b0, 5'd0,  32'h0000_0000, 2'b01};
      tbl[5]  = '{1'b1, 5'd6,  32'h6666_0006, 1'b0, 5'd0,  32'h0000_0000, 2'b01};
      tbl[6]  = '{1'b1, 5'd8,  32'h8888_0008, 1'b1, 5'd9,  32'h9999_0009, 2'b10};
      tbl[7]  = '{1'b1, 5'd8,  32'h8888_0008, 1'b0, 5'd0,  32'h0000_0000, 2'b01};
      tbl[8]  = '{1'b0, 5'd0,  32'h0000_0000, 1'b1, 5'd0,  32'h0000_1234, 2'b10};
      tbl[9]  = '{1'b1, 5'd10, 32'hAAAA_000A, 1'b1, 5'd11, 32'hBBBB_000B, 2'b01};
      tbl[10] = '{1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 2'b00};
      tbl[11] = '{1'b1, 5'd12, 32'hCCCC_000C, 1'b1, 5'd11, 32'hBBBB_000B, 2'b10};

      RST = 1'b0;
      iss_valid = 1'b0; iss_wr = 1'b0; iss_rs1 = 5'd0; iss_rs2 = 5'd0; iss_rd = 5'd0;
      alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
      lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
      m_reset();

      // Reset held with both producers requesting
      repeat (2) @(posedge CLK);
      alu_valid = 1'b1; lsu_valid = 1'b1; alu_rd = 5'd1; lsu_rd = 5'd2;
      @(negedge CLK);
      chk("rst_we", {63'd0, rf_we}, 64'd0);
      chk("rst_busy", {32'd0, busy_vec}, 64'd0);
      chk("rst_ready", {62'd0, lsu_ready, alu_ready}, 64'd0);
      @(posedge CLK); #1;
      RST = 1'b1;

      // Arbitration table
      for (int i = 0; i < 12; i++) begin
         alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].adat;
         lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_data = tbl[i].ldat;
         tick();
         chk("tbl_grant", {62'd0, s_lr, s_ar}, {62'd0, tbl[i].eg});
         exp_rd = tbl[i].eg[1] ? tbl[i].lrd : tbl[i].ard;
         exp_d  = tbl[i].eg[1] ? tbl[i].ldat : tbl[i].adat;
         exp_we = (tbl[i].eg != 2'b00) && (exp_rd != 5'd0);
         chk("tbl_we", {63'd0, rf_we}, {63'd0, exp_we});
         if (exp_we) begin
            chk("tbl_addr", {59'd0, rf_waddr}, {59'd0, exp_rd});
            chk("tbl_data", {32'd0, rf_wdata}, {32'd0, exp_d});
         end
      end
      alu_valid = 1'b0; lsu_valid = 1'b0;
      tick();

      // Issue x5, ALU writes it back, then it reads the new value
      iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 5'd5; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
      tick();
      chk("x5_busy", {63'd0, busy_vec[5]}, 64'd1);
      iss_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
      tick();
      chk("x5_ready", {63'd0, s_ar}, 64'd1);
      alu_valid = 1'b0;
      chk("x5_we", {63'd0, rf_we}, 64'd1);
      chk("x5_wdata", {32'd0, rf_wdata}, 64'h0000_0000_DEAD_BEEF);
      tick();
      chk("x5_clear", {63'd0, busy_vec[5]}, 64'd0);
      chk("x5_read", {32'd0, mem[5]}, 64'h0000_0000_DEAD_BEEF);

      // Issue with rd=0 never marks a register busy
      iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 5'd0;
      tick();
      iss_valid = 1'b0;
      chk("x0_busy", {32'd0, busy_vec}, 64'd0);

      // RAW and WAW stalls on x7 until the cycle after its commit
      iss_valid = 1'b1; iss_rd = 5'd7;
      tick();
      iss_rs2 = 5'd7; iss_rd = 5'd3;
      tick();
      chk("raw_stall", {63'd0, s_stall}, 64'd1);
      iss_rs2 = 5'd0; iss_rd = 5'd7;
      tick();
      chk("waw_stall", {63'd0, s_stall}, 64'd1);
      iss_rs2 = 5'd7; iss_rd = 5'd3;
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0077;
      tick();
      alu_valid = 1'b0;
      tick();
      chk("commit_stall", {63'd0, s_stall}, 64'd1);
      tick();
      chk("released", {63'd0, s_stall}, 64'd0);
      iss_valid = 1'b0; iss_rs2 = 5'd0;

      // Asynchronous reset while a write is pending
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0099;
      tick();
      alu_valid = 1'b0;
      chk("pre_rst_we", {63'd0, rf_we}, 64'd1);
      chk("pre_rst_busy", {63'd0, busy_vec[3]}, 64'd1);
      #2 RST = 1'b0;
      #1;
      chk("async_we", {63'd0, rf_we}, 64'd0);
      chk("async_busy", {32'd0, busy_vec}, 64'd0);
      @(posedge CLK); #1;
      RST = 1'b1;
      m_reset();

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         iss_valid = ($urandom_range(0, 99) < 70);
         iss_wr    = ($urandom_range(0, 99) < 80);
         iss_rs1   = 5'($urandom_range(0, 9));
         iss_rs2   = 5'($urandom_range(0, 9));
         iss_rd    = 5'($urandom_range(0, 9));
         if (!alu_valid || e_ga) begin
            alu_valid = ($urandom_range(0, 99) < 60);
            alu_rd    = pick_rd();
            alu_data  = $urandom;
         end
         if (!lsu_valid || e_gl) begin
            lsu_valid = ($urandom_range(0, 99) < 50);
            lsu_rd    = pick_rd();
            lsu_data  = $urandom;
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
